// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester ports, the shared response bus and the MMU
// load/store port. The arbiter is the slave side; the requesters plus the
// MMU together form the master side.
interface mem_port_arbiter_if;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0]       req_we;
   logic [1:0][1:0]  req_unit;
   logic [1:0][31:0] req_addr;
   logic [1:0][31:0] req_wd;

   logic [1:0]       resp_valid;
   logic [31:0]      resp_rd;
   logic             resp_access_fault;
   logic             resp_misaligned;

   logic             mmu_re;
   logic             mmu_we;
   logic [1:0]       mmu_rd_unit;
   logic [1:0]       mmu_wd_unit;
   logic [31:0]      mmu_addr;
   logic [31:0]      mmu_wd;
   logic [31:0]      mmu_rd;
   logic             mmu_access_fault;
   logic             mmu_addr_misaligned;

   modport slave (
      input  req_valid, req_we, req_unit, req_addr, req_wd,
      input  mmu_rd, mmu_access_fault, mmu_addr_misaligned,
      output req_ready, resp_valid, resp_rd, resp_access_fault, resp_misaligned,
      output mmu_re, mmu_we, mmu_rd_unit, mmu_wd_unit, mmu_addr, mmu_wd
   );

   modport master (
      output req_valid, req_we, req_unit, req_addr, req_wd,
      output mmu_rd, mmu_access_fault, mmu_addr_misaligned,
      input  req_ready, resp_valid, resp_rd, resp_access_fault, resp_misaligned,
      input  mmu_re, mmu_we, mmu_rd_unit, mmu_wd_unit, mmu_addr, mmu_wd
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single MMU load/store port.
// Port 0 (LSU) has fixed priority; port 1 (fetch) is forced through after
// STARVE_LIMIT consecutive port-0 grants made while it was waiting.
// One transaction at a time: IDLE accepts, ACCESS holds the latched request
// on the MMU for WAIT_STATES+1 cycles, then a one-cycle registered response.
module mem_port_arbiter #(
   parameter int WAIT_STATES  = 0,
   parameter int STARVE_LIMIT = 4
) (
   input logic               clk,
   input logic               rst_n,
   mem_port_arbiter_if.slave bus
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [3:0]    WAIT_INIT  = 4'(WAIT_STATES);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t         state_q;
   logic           port_q;
   logic           we_q;
   logic [1:0]     unit_q;
   logic [31:0]    addr_q;
   logic [31:0]    wd_q;
   logic [3:0]     wait_q;
   logic [SW-1:0]  starve_q;
   logic [SW-1:0]  starve_d;
   logic [1:0]     resp_valid_q;
   logic [31:0]    resp_rd_q;
   logic           resp_af_q;
   logic           resp_mis_q;

   logic           grant_p0;
   logic           grant_p1;
   logic           accept;
   logic           starve_at_limit;
   logic           last_cycle;

   assign starve_at_limit = (starve_q == STARVE_MAX);
   assign last_cycle      = (wait_q == '0);

   // Combinational grant and starvation-counter next value for the IDLE accept cycle
   always_comb begin
      grant_p1 = bus.req_valid[1] & (~bus.req_valid[0] | starve_at_limit);
      grant_p0 = bus.req_valid[0] & ~grant_p1;
      accept   = rst_n & (state_q == IDLE) & (grant_p0 | grant_p1);
      starve_d = starve_q;
      if (accept & grant_p1) begin
         starve_d = '0;
      end else if (accept & bus.req_valid[1] & ~starve_at_limit) begin
         starve_d = starve_q + SW'(1);
      end
   end

   assign bus.req_ready = accept ? {grant_p1, grant_p0} : 2'b00;

   // MMU port driven straight from the latched request; the write strobe is
   // confined to the final ACCESS cycle so every store hits the MMU once.
   assign bus.mmu_addr    = addr_q;
   assign bus.mmu_wd      = wd_q;
   assign bus.mmu_rd_unit = unit_q;
   assign bus.mmu_wd_unit = unit_q;
   assign bus.mmu_re      = (state_q == ACCESS) & ~we_q;
   assign bus.mmu_we      = (state_q == ACCESS) & we_q & last_cycle;

   assign bus.resp_valid        = resp_valid_q;
   assign bus.resp_rd           = resp_rd_q;
   assign bus.resp_access_fault = resp_af_q;
   assign bus.resp_misaligned   = resp_mis_q;

   // FSM, request latch, wait counter, starvation counter and response registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         port_q       <= 1'b0;
         we_q         <= 1'b0;
         unit_q       <= '0;
         addr_q       <= '0;
         wd_q         <= '0;
         wait_q       <= '0;
         starve_q     <= '0;
         resp_valid_q <= '0;
         resp_rd_q    <= '0;
         resp_af_q    <= 1'b0;
         resp_mis_q   <= 1'b0;
      end else begin
         resp_valid_q <= '0;
         starve_q     <= starve_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  port_q  <= grant_p1;
                  we_q    <= bus.req_we[grant_p1];
                  unit_q  <= bus.req_unit[grant_p1];
                  addr_q  <= bus.req_addr[grant_p1];
                  wd_q    <= bus.req_wd[grant_p1];
                  wait_q  <= WAIT_INIT;
                  state_q <= ACCESS;
               end
            end
            ACCESS: begin
               if (last_cycle) begin
                  resp_valid_q[port_q] <= 1'b1;
                  resp_rd_q  <= (~we_q & ~bus.mmu_access_fault & ~bus.mmu_addr_misaligned)
                                ? bus.mmu_rd : '0;
                  resp_af_q  <= bus.mmu_access_fault;
                  resp_mis_q <= bus.mmu_addr_misaligned;
                  state_q    <= IDLE;
               end else begin
                  wait_q <= wait_q - 4'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three DUT configurations run side by side,
// each with its own requester queues, MMU model, reference model and a
// response monitor fed by an expected-response queue.
module tb_mem_port_arbiter;

   typedef struct {
      bit          we;
      logic [1:0]  unit;
      logic [31:0] addr;
      logic [31:0] wd;
   } req_t;

   typedef struct {
      int          port;
      logic [31:0] rd;
      bit          af;
      bit          mis;
      int          due;
   } resp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input int cfg, input string name,
                        input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL cfg%0d %s: got 0x%0h, expected 0x%0h", cfg, name, act, exp);
      end
   endtask

   // MMU behaviour seen by the bench: data is an address hash, the top
   // 256 MiB faults, half/word accesses must be naturally aligned.
   function automatic logic [31:0] mmu_data(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h13579BDF);
   endfunction

   function automatic bit mmu_af(input logic [31:0] a);
      return a[31:28] == 4'hF;
   endfunction

   function automatic bit mmu_mis(input logic [31:0] a, input logic [1:0] u);
      return (u == 2'b01 && a[0]) || (u == 2'b10 && a[1:0] != 2'b00);
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.we   = 1'($urandom_range(0, 1));
      r.unit = 2'($urandom_range(0, 2));
      r.addr = $urandom;
      if ($urandom_range(0, 1) == 0) r.addr[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) r.addr[31:28] = 4'hF;
      r.wd   = $urandom;
      return r;
   endfunction

   for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
      localparam int WS = (gi == 0) ? 0 : ((gi == 1) ? 3 : 2);
      localparam int SL = (gi == 2) ? 2 : 4;

      logic rst_n;
      mem_port_arbiter_if bus();

      assign bus.mmu_rd              = mmu_data(bus.mmu_addr);
      assign bus.mmu_access_fault    = mmu_af(bus.mmu_addr);
      assign bus.mmu_addr_misaligned = mmu_mis(bus.mmu_addr, bus.mmu_rd_unit);

      mem_port_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(SL)) dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (bus)
      );

      req_t  q0[$];
      req_t  q1[$];
      resp_t exp_q[$];
      int    grant_log[$];
      req_t  cur;
      int    starve = 0;
      int    busy_last = -1;
      int    acc_cyc = -10;
      int    rst_cycles = 0;
      int    rst_at = -1;
      int    mid_resets = 0;
      bit    arm_rst = 0;
      bit    log_en = 0;
      bit    mode = 0;
      bit    done = 0;
      bit    post_rst = 0;
      logic [1:0] v;

      task automatic drain();
         int k;
         k = 0;
         while (k < 3000 && !(q0.size() == 0 && q1.size() == 0 && exp_q.size() == 0 &&
                              rst_cycles == 0 && rst_n === 1'b1 && !post_rst &&
                              cyc > busy_last + 1)) begin
            @(negedge clk);
            k++;
         end
         if (k >= 3000)
            check(gi, "drain_timeout", 128'(q0.size() + q1.size() + exp_q.size()), 128'(0));
      endtask

      // Requester driver plus reference model: drives inputs after each
      // rising edge, checks the grant and MMU side at the falling edge.
      initial begin
         bit    have;
         req_t  r;
         int    g;
         logic [1:0] exp_ready;
         bit    in_acc;
         bit    eaf;
         bit    emis;
         resp_t e;
         rst_n         = 1'b0;
         bus.req_valid = '0;
         bus.req_we    = '0;
         bus.req_unit  = '0;
         bus.req_addr  = '0;
         bus.req_wd    = '0;
         forever begin
            @(posedge clk);
            #1;
            if (rst_cycles > 0) begin
               rst_n = 1'b0;
               rst_cycles--;
            end else if (cyc == rst_at) begin
               rst_n = 1'b0;
               mid_resets++;
            end else begin
               rst_n = 1'b1;
            end
            for (int p = 0; p < 2; p++) begin
               have = (p == 0) ? (q0.size() > 0) : (q1.size() > 0);
               v[p] = have && rst_n && !post_rst && (mode == 0 || $urandom_range(0, 3) != 0);
               if (v[p]) r = (p == 0) ? q0[0] : q1[0];
               else      r = rand_req();
               bus.req_we[p]   = r.we;
               bus.req_unit[p] = r.unit;
               bus.req_addr[p] = r.addr;
               bus.req_wd[p]   = r.wd;
            end
            bus.req_valid = v;

            @(negedge clk);
            if (post_rst) begin
               check(gi, "reset_outputs",
                     128'({bus.req_ready, bus.resp_valid, bus.resp_rd, bus.resp_access_fault,
                           bus.resp_misaligned, bus.mmu_re, bus.mmu_we, bus.mmu_rd_unit,
                           bus.mmu_wd_unit, bus.mmu_addr, bus.mmu_wd}), '0);
            end else if (rst_n) begin
               in_acc = (cyc >= acc_cyc + 1) && (cyc <= busy_last);
               if (in_acc)
                  check(gi, "mmu_access",
                        128'({bus.mmu_re, bus.mmu_we, bus.mmu_rd_unit, bus.mmu_wd_unit,
                              bus.mmu_addr, bus.mmu_wd}),
                        128'({!cur.we, cur.we && (cyc == busy_last), cur.unit, cur.unit,
                              cur.addr, cur.wd}));
               else
                  check(gi, "mmu_idle", 128'({bus.mmu_re, bus.mmu_we}), 128'(2'b00));
            end

            g = -1;
            if (rst_n && cyc > busy_last) begin
               if (v[1] && (!v[0] || starve == SL)) g = 1;
               else if (v[0])                      g = 0;
            end
            exp_ready = (g == 0) ? 2'b01 : ((g == 1) ? 2'b10 : 2'b00);
            check(gi, "req_ready", 128'(bus.req_ready), 128'(exp_ready));

            if (g >= 0) begin
               cur       = (g == 0) ? q0.pop_front() : q1.pop_front();
               acc_cyc   = cyc;
               busy_last = cyc + 1 + WS;
               eaf       = mmu_af(cur.addr);
               emis      = mmu_mis(cur.addr, cur.unit);
               e.port    = g;
               e.af      = eaf;
               e.mis     = emis;
               e.rd      = (!cur.we && !eaf && !emis) ? mmu_data(cur.addr) : 32'h0;
               e.due     = cyc + 2 + WS;
               exp_q.push_back(e);
               if (g == 1)    starve = 0;
               else if (v[1]) starve = (starve < SL) ? starve + 1 : SL;
               if (log_en) grant_log.push_back(g);
               if (arm_rst && cur.we) begin
                  rst_at  = cyc + ((WS > 0) ? 2 : 1);
                  arm_rst = 0;
               end
            end

            if (!rst_n) begin
               exp_q.delete();
               busy_last = -1;
               acc_cyc   = -10;
               starve    = 0;
            end
            post_rst = !rst_n;
         end
      end

      // Response monitor: every strobe must match the oldest expected response
      initial begin
         resp_t e;
         while (!done) begin
            @(negedge clk);
            if (bus.resp_valid !== 2'b00) begin
               if (exp_q.size() == 0) begin
                  check(gi, "unexpected_resp", 128'(bus.resp_valid), 128'(2'b00));
               end else begin
                  e = exp_q.pop_front();
                  check(gi, "resp",
                        128'({bus.resp_valid, bus.resp_access_fault, bus.resp_misaligned, bus.resp_rd}),
                        128'({(e.port == 1) ? 2'b10 : 2'b01, e.af, e.mis, e.rd}));
                  check(gi, "resp_cycle", 128'(cyc), 128'(e.due));
               end
            end else if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
               e = exp_q.pop_front();
               check(gi, "missing_resp", 128'(bus.resp_valid),
                     128'((e.port == 1) ? 2'b10 : 2'b01));
            end
         end
      end

      // Test sequence for this configuration
      initial begin
         req_t r;
         int   act;
         rst_cycles = 3;
         drain();

         r = '{we: 1'b0, unit: 2'b10, addr: 32'h0000_0010, wd: 32'h0};
         q0.push_back(r);
         drain();

         r = '{we: 1'b1, unit: 2'b00, addr: 32'h0000_0003, wd: 32'h0000_00A5};
         q1.push_back(r);
         drain();

         log_en = 1;
         for (int i = 0; i < 9; i++) q0.push_back(rand_req());
         for (int i = 0; i < 3; i++) q1.push_back(rand_req());
         drain();
         log_en = 0;
         for (int i = 0; i < 10; i++) begin
            act = (grant_log.size() > i) ? grant_log[i] : 99;
            check(gi, "grant_order", 128'(act), 128'(((i + 1) % (SL + 1) == 0) ? 1 : 0));
         end

         r = '{we: 1'b0, unit: 2'b01, addr: 32'h0000_0001, wd: 32'h0};
         q0.push_back(r);
         r = '{we: 1'b0, unit: 2'b10, addr: 32'hF000_0000, wd: 32'h0};
         q0.push_back(r);
         r = '{we: 1'b0, unit: 2'b10, addr: 32'h0000_0020, wd: 32'h0};
         q0.push_back(r);
         drain();

         mode = 1;
         for (int i = 0; i < 60; i++) begin
            q0.push_back(rand_req());
            q1.push_back(rand_req());
         end
         drain();
         mode = 0;

         arm_rst = 1;
         r = '{we: 1'b1, unit: 2'b10, addr: 32'h0000_0040, wd: 32'h1234_5678};
         q1.push_back(r);
         drain();
         check(gi, "mid_reset_applied", 128'(mid_resets), 128'(1));

         r = '{we: 1'b0, unit: 2'b10, addr: 32'h0000_0010, wd: 32'h0};
         q0.push_back(r);
         drain();
         done = 1;
      end
   end

   initial begin
      fork
         wait (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done);
         #500_000;
      join_any
      check(-1, "all_configs_done",
            128'({g_cfg[0].done, g_cfg[1].done, g_cfg[2].done}), 128'(3'b111));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
